// File: rtl/game_input_pkg.sv
// Shared encodings for the game input front end: button indices, direction codes,
// pause-state encoding and the move-priority helpers used by the top level.
package game_input_pkg;

  localparam int NUM_BTN = 5;

  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_C = 4;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } state_t;

  // Right > left > up > down, the same chain the block controller evaluates.
  function automatic logic [3:0] move_onehot(input logic [3:0] held);
    logic [3:0] oh;
    oh = '0;
    if (held[BTN_R])      oh[BTN_R] = 1'b1;
    else if (held[BTN_L]) oh[BTN_L] = 1'b1;
    else if (held[BTN_U]) oh[BTN_U] = 1'b1;
    else if (held[BTN_D]) oh[BTN_D] = 1'b1;
    return oh;
  endfunction

  function automatic logic [1:0] dir_code(input logic [3:0] held);
    logic [1:0] code;
    code = DIR_DOWN;
    if (held[BTN_R])      code = DIR_RIGHT;
    else if (held[BTN_L]) code = DIR_LEFT;
    else if (held[BTN_U]) code = DIR_UP;
    return code;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button channel: two-flop synchronizer, stability counter and a
// registered rising-edge pulse delayed one cycle behind the accepted level.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_stable,
  output logic o_press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
      r_press    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= i_btn;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      // Any cycle where the synchronized level agrees with the accepted one restarts the count.
      if (r_sync2 != r_stable) begin
        if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_press  = r_press;

endmodule

// File: rtl/direction_input_conditioner.sv
// Button front end for the block controller: debounced buttons, game-rate tick,
// pause FSM, prioritized one-hot move strobes and last-direction tracking.
module direction_input_conditioner
  import game_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TICK_DIV        = 1666667,
  parameter int unsigned CNT_W           = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  output logic       tick,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [4:0] press,
  output logic [1:0] last_dir,
  output logic       dir_valid,
  output logic       paused
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_press;
  logic               w_unused_center_level;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_tick_cnt;
  logic               w_tick;
  logic [3:0]         w_move;
  logic [1:0]         r_last_dir;
  logic               r_dir_valid;

  assign w_btn_raw[BTN_U] = btn_up;
  assign w_btn_raw[BTN_D] = btn_down;
  assign w_btn_raw[BTN_L] = btn_left;
  assign w_btn_raw[BTN_R] = btn_right;
  assign w_btn_raw[BTN_C] = btn_center;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debouncer (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (w_btn_raw[gi]),
        .o_stable(w_stable[gi]),
        .o_press (w_press[gi])
      );
    end
  endgenerate

  // Only the press pulse of the center button matters; its level is not a move.
  assign w_unused_center_level = w_stable[BTN_C];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_press[BTN_C]) begin
      case (r_state)
        ST_RUN:    w_state_next = ST_PAUSED;
        ST_PAUSED: w_state_next = ST_RUN;
        default:   w_state_next = ST_RUN;
      endcase
    end
  end

  // Clearing on entry as well as while paused makes a resume start a full period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (r_state == ST_PAUSED || w_state_next == ST_PAUSED) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  assign w_tick = (r_state == ST_RUN) && (r_tick_cnt == TICK_LAST);
  assign w_move = w_tick ? move_onehot(w_stable[3:0]) : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_dir  <= DIR_UP;
      r_dir_valid <= 1'b0;
    end else if (|w_press[3:0]) begin
      r_last_dir  <= dir_code(w_press[3:0]);
      r_dir_valid <= 1'b1;
    end
  end

  assign tick      = w_tick;
  assign up        = w_move[BTN_U];
  assign down      = w_move[BTN_D];
  assign left      = w_move[BTN_L];
  assign right     = w_move[BTN_R];
  assign press     = w_press;
  assign last_dir  = r_last_dir;
  assign dir_valid = r_dir_valid;
  assign paused    = (r_state == ST_PAUSED);

endmodule

// File: tb/tb_direction_input_conditioner.sv
// Directed bench for direction_input_conditioner with short debounce and tick periods.
module tb_direction_input_conditioner;

  localparam int DEB  = 4;
  localparam int TDIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_center = 1'b0;
  logic       tick, up, down, left, right, dir_valid, paused;
  logic [4:0] press;
  logic [1:0] last_dir;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc_n     = 0;
  int tick_base = 0;

  always #5 clk = ~clk;

  direction_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_DIV       (TDIV),
    .CNT_W          (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_center(btn_center),
    .tick      (tick),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .press     (press),
    .last_dir  (last_dir),
    .dir_valid (dir_valid),
    .paused    (paused)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
  endtask

  function automatic logic exp_tick();
    return ((cyc_n - tick_base) % TDIV) == (TDIV - 1);
  endfunction

  function automatic logic [3:0] strobes();
    return {right, left, down, up};
  endfunction

  function automatic logic [31:0] all_out();
    return 32'({tick, up, down, left, right, press, last_dir, dir_valid, paused});
  endfunction

  initial begin
    // Reset state, then free-running tick with no buttons.
    repeat (2) @(negedge clk);
    check("reset_outputs", all_out(), 32'd0);
    rst = 1'b1;
    cyc_n = 0;
    tick_base = 0;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      check("t1_tick", 32'(tick), 32'(exp_tick()));
      check("t1_strobes", 32'(strobes()), 32'd0);
    end
    check("t1_dir_valid", 32'(dir_valid), 32'd0);
    check("t1_paused", 32'(paused), 32'd0);
    $display("phase 1 reset/tick done, checks=%0d", n_checks);

    // Right held: one press pulse 7 cycles after the edge, right on each tick after that.
    btn_right = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check("t2_press", 32'(press), (k == 7) ? 32'h08 : 32'h00);
      check("t2_strobes", 32'(strobes()), (k >= 6 && exp_tick()) ? 32'h8 : 32'h0);
      check("t2_tick", 32'(tick), 32'(exp_tick()));
    end
    check("t2_last_dir", 32'(last_dir), 32'd3);
    check("t2_dir_valid", 32'(dir_valid), 32'd1);
    btn_right = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check("t2_release_press", 32'(press), 32'd0);
    end
    $display("phase 2 right press done, checks=%0d", n_checks);

    // Up bouncing every 2 cycles never settles.
    for (int k = 0; k < 30; k++) begin
      if (k % 2 == 0) btn_up = ~btn_up;
      cyc();
      check("t3_press", 32'(press), 32'd0);
      check("t3_strobes", 32'(strobes()), 32'd0);
    end
    btn_up = 1'b0;
    repeat (8) cyc();
    $display("phase 3 bounce rejection done, checks=%0d", n_checks);

    // Right+left together, then up: right wins strobes, simultaneous press gives right.
    btn_right = 1'b1;
    btn_left  = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      if (k == 11) btn_up = 1'b1;
      cyc();
      check("t4_press", 32'(press), (k == 7) ? 32'h0C : (k == 17) ? 32'h01 : 32'h00);
      check("t4_strobes", 32'(strobes()), (k >= 6 && exp_tick()) ? 32'h8 : 32'h0);
      if (k == 9) check("t4_last_dir_simul", 32'(last_dir), 32'd3);
    end
    check("t4_last_dir_up", 32'(last_dir), 32'd0);
    btn_right = 1'b0;
    btn_up    = 1'b0;
    repeat (8) cyc();
    $display("phase 4 priority done, checks=%0d", n_checks);

    // Pause with left held; down pressed while paused still updates last_dir.
    btn_center = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      if (k == 11) btn_center = 1'b0;
      if (k == 21) btn_down = 1'b1;
      if (k == 36) btn_down = 1'b0;
      cyc();
      check("t5_press_c", 32'(press[4]), 32'(k == 7));
      check("t5_press_d", 32'(press[1]), 32'(k == 27));
      if (k <= 7) begin
        check("t5_run_tick", 32'(tick), 32'(exp_tick()));
        check("t5_run_strobes", 32'(strobes()), exp_tick() ? 32'h4 : 32'h0);
        check("t5_run_paused", 32'(paused), 32'd0);
      end else begin
        check("t5_pause_tick", 32'(tick), 32'd0);
        check("t5_pause_strobes", 32'(strobes()), 32'd0);
        check("t5_pause_paused", 32'(paused), 32'd1);
      end
    end
    check("t5_last_dir_paused", 32'(last_dir), 32'd1);

    // Resume: first tick on the 8th cycle after the center press pulse.
    btn_center = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      if (j == 11) btn_center = 1'b0;
      cyc();
      check("t5r_press_c", 32'(press[4]), 32'(j == 7));
      if (j <= 7) begin
        check("t5r_paused_hold", 32'(paused), 32'd1);
        check("t5r_tick_hold", 32'(tick), 32'd0);
        if (j == 7) tick_base = cyc_n + 1;
      end else begin
        check("t5r_paused", 32'(paused), 32'd0);
        check("t5r_tick", 32'(tick), 32'(exp_tick()));
        check("t5r_strobes", 32'(strobes()), exp_tick() ? 32'h4 : 32'h0);
      end
    end
    $display("phase 5 pause/resume done, checks=%0d", n_checks);

    // Asynchronous reset mid-debounce and mid-tick with right held.
    btn_left  = 1'b0;
    btn_right = 1'b1;
    repeat (4) cyc();
    #2 rst = 1'b0;
    #1 check("t6_async_reset", all_out(), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc_n = 0;
    tick_base = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check("t6_press", 32'(press), (k == 7) ? 32'h08 : 32'h00);
      check("t6_tick", 32'(tick), 32'(exp_tick()));
      check("t6_strobes", 32'(strobes()), (k >= 6 && exp_tick()) ? 32'h8 : 32'h0);
      check("t6_dir_valid", 32'(dir_valid), 32'(k >= 8));
      check("t6_paused", 32'(paused), 32'd0);
    end
    $display("phase 6 reset mid-count done, checks=%0d", n_checks);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
